traffic_sensor_cond: RTL and testbench

Input-conditioning stage directly upstream of the traffic-light controller. Takes four raw, asynchronous field signals (street-A and street-B vehicle loop sensors, parade-start and parade-end switches) and produces the clean, clock-synchronous `Ta`, `Tb`, `P`, `R` the controller consumes. Each input is 2-flop synchronized and debounced. `Ta`/`Tb` are delivered as debounced levels; `P`/`R` are delivered as single-cycle pulses on debounced rising edges.

---
 rtl/traffic_pkg.sv | 10 +
 rtl/sensor_debounce.sv | 53 +++++
 rtl/traffic_sensor_cond.sv | 52 +++++
 tb/tb_traffic_sensor_cond.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Constants shared between the sensor conditioning stage and the traffic-light controller.
package traffic_pkg;

    localparam int DEB_CYCLES_DEFAULT = 8;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

endpackage

// File: rtl/sensor_debounce.sv
// One field-input channel: 2-flop synchronizer, consecutive-mismatch debounce counter
// and a registered rising-edge pulse that lines up with the debounced level change.
module sensor_debounce #(
    parameter int DEB_CYCLES = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic s1;
    logic s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // A single matching sample clears the count, so only an unbroken run of
    // DEB_CYCLES mismatches can move the level; rise is registered alongside it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level <= 1'b0;
            rise  <= 1'b0;
            cnt   <= '0;
        end else begin
            rise <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s2;
                rise  <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    cnt_bounded: assert property (@(posedge clk) disable iff (!rstn) cnt <= CNT_LAST);

endmodule

// File: rtl/traffic_sensor_cond.sv
// Conditions the four raw field inputs into the clean Ta/Tb levels and P/R pulses
// consumed by the traffic-light controller.
module traffic_sensor_cond
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic ta_raw,
    input  logic tb_raw,
    input  logic p_raw,
    input  logic r_raw,
    output logic Ta,
    output logic Tb,
    output logic P,
    output logic R
);

    logic ta_rise;
    logic tb_rise;
    logic p_level;
    logic r_level;
    logic p_rise;
    logic r_rise;
    logic unused_ok;

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ta (
        .clk(clk), .rstn(rstn), .raw(ta_raw), .level(Ta), .rise(ta_rise)
    );

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_tb (
        .clk(clk), .rstn(rstn), .raw(tb_raw), .level(Tb), .rise(tb_rise)
    );

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_p (
        .clk(clk), .rstn(rstn), .raw(p_raw), .level(p_level), .rise(p_rise)
    );

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_r (
        .clk(clk), .rstn(rstn), .raw(r_raw), .level(r_level), .rise(r_rise)
    );

    // End-of-parade wins when both switches qualify on the same edge.
    assign R = r_rise;
    assign P = p_rise & ~r_rise;

    assign unused_ok = ta_rise ^ tb_rise ^ p_level ^ r_level;

    pr_exclusive: assert property (@(posedge clk) disable iff (!rstn) !(P && R));

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Scoreboard bench for traffic_sensor_cond: a sliding-window reference predicts every
// output vector, and each scenario task also checks edge timing and pulse counts.
`timescale 1ns/1ps
module tb_traffic_sensor_cond;
    import traffic_pkg::*;

    localparam int DEB = 8;

    typedef struct {
        int   edge_no;
        logic ta;
        logic tb;
        logic p;
        logic r;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic ta_raw = 1'b0;
    logic tb_raw = 1'b0;
    logic p_raw = 1'b0;
    logic r_raw = 1'b0;
    logic Ta, Tb, P, R;

    int vectors = 0;
    int miscompares = 0;
    int edge_num = 0;

    exp_t sb[$];
    logic [DEB-1:0] hist [4];
    logic md [4];

    int ta_rises, ta_last_rise, ta_last_fall;
    int tb_rises, tb_last_rise;
    int p_cycles, r_cycles, r_last;
    logic ta_prev = 1'b0;
    logic tb_prev = 1'b0;

    traffic_sensor_cond #(.DEB_CYCLES(DEB)) dut (
        .clk(clk), .rstn(rstn),
        .ta_raw(ta_raw), .tb_raw(tb_raw), .p_raw(p_raw), .r_raw(r_raw),
        .Ta(Ta), .Tb(Tb), .P(P), .R(R)
    );

    always #5 clk = ~clk;

    // Pop the prediction for this edge and keep event trackers for the scenario tasks.
    always @(posedge clk) begin
        exp_t got;
        edge_num++;
        #1;
        if (sb.size() > 0 && sb[0].edge_no <= edge_num) begin
            got = sb.pop_front();
            vectors++;
            if (got.edge_no != edge_num || {Ta, Tb, P, R} !== {got.ta, got.tb, got.p, got.r}) begin
                miscompares++;
                $display("[TB] FAIL sb_edge%0d: TaTbPR got %b%b%b%b, want %b%b%b%b (pred edge %0d)",
                         edge_num, Ta, Tb, P, R, got.ta, got.tb, got.p, got.r, got.edge_no);
            end
        end
        if (Ta && !ta_prev) begin ta_rises++; ta_last_rise = edge_num; end
        if (!Ta && ta_prev) ta_last_fall = edge_num;
        if (Tb && !tb_prev) begin tb_rises++; tb_last_rise = edge_num; end
        if (P) p_cycles++;
        if (R) begin r_cycles++; r_last = edge_num; end
        ta_prev = Ta;
        tb_prev = Tb;
    end

    task automatic clear_trackers();
        ta_rises = 0; ta_last_rise = -1; ta_last_fall = -1;
        tb_rises = 0; tb_last_rise = -1;
        p_cycles = 0; r_cycles = 0; r_last = -1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < 4; c++) begin
            hist[c] = '0;
            md[c] = 1'b0;
        end
        sb.delete();
    endtask

    // Called just after a negedge: drives one sample and predicts the outputs two edges later.
    task automatic drive(input logic a, input logic b, input logic p, input logic r);
        logic s [4];
        logic rs [4];
        exp_t e;
        s = '{a, b, p, r};
        ta_raw = a; tb_raw = b; p_raw = p; r_raw = r;
        for (int c = 0; c < 4; c++) begin
            hist[c] = {hist[c][DEB-2:0], s[c]};
            rs[c] = 1'b0;
            if (hist[c] == '1 && !md[c]) begin
                md[c] = 1'b1;
                rs[c] = 1'b1;
            end else if (hist[c] == '0 && md[c]) begin
                md[c] = 1'b0;
            end
        end
        e.edge_no = edge_num + 3;
        e.ta = md[0];
        e.tb = md[1];
        e.r  = rs[3];
        e.p  = rs[2] & ~rs[3];
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset(input int hold);
        #2 rstn = 1'b0;
        #1;
        vectors++;
        if ({Ta, Tb, P, R} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL async_reset: TaTbPR got %b%b%b%b, want 0000", Ta, Tb, P, R);
        end
        model_clear();
        repeat (hold) begin
            @(negedge clk);
            vectors++;
            if ({Ta, Tb, P, R} !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL reset_hold: TaTbPR got %b%b%b%b, want 0000", Ta, Tb, P, R);
            end
        end
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        int e0;
        ta_raw = 1'b1; tb_raw = 1'b1; p_raw = 1'b1; r_raw = 1'b1;
        model_clear();
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if ({Ta, Tb, P, R} !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL reset_state: TaTbPR got %b%b%b%b, want 0000", Ta, Tb, P, R);
            end
        end
        clear_trackers();
        rstn = 1'b1;
        e0 = edge_num + 1;
        repeat (20) drive(1, 1, 1, 1);
        vectors++;
        if (ta_last_rise != e0 + 9 || tb_last_rise != e0 + 9) begin
            miscompares++;
            $display("[TB] FAIL reset_release_levels: Ta rise %0d Tb rise %0d, want %0d", ta_last_rise, tb_last_rise, e0 + 9);
        end
        vectors++;
        if (r_cycles != 1 || r_last != e0 + 9 || p_cycles != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_release_pulses: R cycles %0d at %0d, P cycles %0d, want 1 at %0d and 0",
                     r_cycles, r_last, p_cycles, e0 + 9);
        end
        do_reset(3);
        repeat (12) drive(0, 0, 0, 0);
    endtask

    task automatic test_glitch();
        int e0, e1;
        clear_trackers();
        repeat (7) drive(1, 0, 0, 0);
        repeat (12) drive(0, 0, 0, 0);
        vectors++;
        if (ta_rises != 0) begin
            miscompares++;
            $display("[TB] FAIL glitch_reject: Ta rises %0d, want 0", ta_rises);
        end
        e0 = edge_num + 1;
        repeat (10) drive(1, 0, 0, 0);
        e1 = edge_num + 1;
        repeat (12) drive(0, 0, 0, 0);
        vectors++;
        if (ta_rises != 1 || ta_last_rise != e0 + 9 || ta_last_fall != e1 + 9) begin
            miscompares++;
            $display("[TB] FAIL glitch_accept: rises %0d rise@%0d fall@%0d, want 1 rise@%0d fall@%0d",
                     ta_rises, ta_last_rise, ta_last_fall, e0 + 9, e1 + 9);
        end
    endtask

    task automatic test_bounce();
        int e0;
        logic pat [8];
        pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        clear_trackers();
        for (int i = 0; i < 8; i++) drive(0, pat[i], 0, 0);
        e0 = edge_num + 1;
        repeat (15) drive(0, 1, 0, 0);
        vectors++;
        if (tb_rises != 1 || tb_last_rise != e0 + 9) begin
            miscompares++;
            $display("[TB] FAIL bounce: Tb rises %0d at %0d, want 1 at %0d", tb_rises, tb_last_rise, e0 + 9);
        end
    endtask

    task automatic test_single_pulse();
        clear_trackers();
        repeat (100) drive(0, 0, 1, 0);
        vectors++;
        if (p_cycles != 1 || r_cycles != 0) begin
            miscompares++;
            $display("[TB] FAIL single_pulse: P cycles %0d R cycles %0d, want 1 and 0", p_cycles, r_cycles);
        end
        repeat (20) drive(0, 0, 0, 0);
        repeat (20) drive(0, 0, 1, 0);
        vectors++;
        if (p_cycles != 2) begin
            miscompares++;
            $display("[TB] FAIL second_pulse: P cycles %0d, want 2", p_cycles);
        end
    endtask

    task automatic test_simultaneous();
        repeat (15) drive(0, 0, 0, 0);
        clear_trackers();
        repeat (20) drive(0, 0, 1, 1);
        vectors++;
        if (r_cycles != 1 || p_cycles != 0) begin
            miscompares++;
            $display("[TB] FAIL simultaneous: R cycles %0d P cycles %0d, want 1 and 0", r_cycles, p_cycles);
        end
        repeat (15) drive(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        int e0;
        clear_trackers();
        repeat (5) drive(1, 0, 0, 0);
        do_reset(3);
        vectors++;
        if (ta_rises != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_hold: Ta rises %0d, want 0", ta_rises);
        end
        clear_trackers();
        e0 = edge_num + 1;
        repeat (15) drive(1, 0, 0, 0);
        vectors++;
        if (ta_rises != 1 || ta_last_rise != e0 + 9) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_release: Ta rises %0d at %0d, want 1 at %0d", ta_rises, ta_last_rise, e0 + 9);
        end
        repeat (15) drive(0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic v [4];
        v = '{1'b0, 1'b0, 1'b0, 1'b0};
        repeat (600) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 9) == 0) v[c] = ~v[c];
            drive(v[0], v[1], v[2], v[3]);
        end
        repeat (15) drive(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL sb_drain: %0d predictions left, want 0", sb.size());
        end
    endtask

    initial begin
        clear_trackers();
        test_reset();
        test_glitch();
        test_bounce();
        test_single_pulse();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
